// File: rtl/mac_package.sv
// Shared constants and state encoding for the accelerator configuration master.
package mac_package;

    localparam logic [31:0] OFF_TRIGGER  = 32'h0000_0000;
    localparam logic [31:0] OFF_ACQUIRE  = 32'h0000_0004;
    localparam logic [31:0] OFF_JOB_BASE = 32'h0000_0040;

    localparam logic [2:0] JOB_A_ADDR     = 3'd0;
    localparam logic [2:0] JOB_B_ADDR     = 3'd1;
    localparam logic [2:0] JOB_C_ADDR     = 3'd2;
    localparam logic [2:0] JOB_D_ADDR     = 3'd3;
    localparam logic [2:0] JOB_NB_ITER    = 3'd4;
    localparam logic [2:0] JOB_LEN_ITER   = 3'd5;
    localparam logic [2:0] JOB_SHIFT_MUL  = 3'd6;
    localparam logic [2:0] JOB_VECTSTRIDE = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ACQ_REQ,
        ST_ACQ_RESP,
        ST_ACQ_WAIT,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_TRIG_REQ,
        ST_TRIG_RESP,
        ST_WAIT_EVT,
        ST_DONE
    } mac_state_e;

    function automatic logic [31:0] job_reg_addr(input logic [31:0] base, input logic [2:0] idx);
        return base + OFF_JOB_BASE + {27'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/mac_cfg_master.sv
// Programs one MAC accelerator job over the periph bus: acquire a context,
// write the eight job registers, trigger, then wait for the completion event.
//
// state      | meaning
// IDLE       | waiting for start_i
// ACQ_REQ    | ACQUIRE read requested, waiting for gnt
// ACQ_RESP   | waiting for ACQUIRE read data
// ACQ_WAIT   | no free context, back off before retrying
// WR_REQ     | job register write requested, waiting for gnt
// WR_RESP    | waiting for write response
// TRIG_REQ   | TRIGGER write requested, waiting for gnt
// TRIG_RESP  | waiting for trigger response
// WAIT_EVT   | accelerator running, waiting for evt_i
// DONE       | done_o pulse, back to IDLE
module mac_cfg_master
    import mac_package::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0010_0000,
    parameter int unsigned RETRY_WAIT = 8,
    parameter int unsigned ID_WIDTH   = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [31:0]         a_addr_i,
    input  logic [31:0]         b_addr_i,
    input  logic [31:0]         c_addr_i,
    input  logic [31:0]         d_addr_i,
    input  logic [31:0]         nb_iter_i,
    input  logic [31:0]         len_iter_i,
    input  logic [15:0]         shift_i,
    input  logic                simplemul_i,
    input  logic [31:0]         vectstride_i,
    input  logic                evt_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [7:0]          job_id_o,
    output logic                periph_req,
    input  logic                periph_gnt,
    output logic [31:0]         periph_add,
    output logic                periph_wen,
    output logic [3:0]          periph_be,
    output logic [31:0]         periph_data,
    output logic [ID_WIDTH-1:0] periph_id,
    input  logic [31:0]         periph_r_data,
    input  logic                periph_r_valid,
    input  logic [ID_WIDTH-1:0] periph_r_id
);

    mac_state_e  state;
    logic [2:0]  wr_idx;
    logic [31:0] retry_cnt;
    logic [31:0] a_addr_q, b_addr_q, c_addr_q, d_addr_q;
    logic [31:0] nb_iter_q, len_iter_q, vectstride_q;
    logic [15:0] shift_q;
    logic        simplemul_q;
    logic        unused_rsp_bits;

    assign unused_rsp_bits = ^{periph_r_id, periph_r_data[30:8]};
    assign busy_o          = (state != ST_IDLE);
    assign periph_id       = '0;

    // Counts are stored as true values and converted to the accelerator's minus-one form here.
    function automatic logic [31:0] job_word(input logic [2:0] idx);
        unique case (idx)
            JOB_A_ADDR:    return a_addr_q;
            JOB_B_ADDR:    return b_addr_q;
            JOB_C_ADDR:    return c_addr_q;
            JOB_D_ADDR:    return d_addr_q;
            JOB_NB_ITER:   return nb_iter_q - 32'd1;
            JOB_LEN_ITER:  return len_iter_q - 32'd1;
            JOB_SHIFT_MUL: return {shift_q - 16'd1, 15'd0, simplemul_q};
            default:       return vectstride_q;
        endcase
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            periph_req   <= 1'b0;
            periph_add   <= '0;
            periph_wen   <= 1'b1;
            periph_be    <= '0;
            periph_data  <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            job_id_o     <= '0;
            wr_idx       <= '0;
            retry_cnt    <= '0;
            a_addr_q     <= '0;
            b_addr_q     <= '0;
            c_addr_q     <= '0;
            d_addr_q     <= '0;
            nb_iter_q    <= '0;
            len_iter_q   <= '0;
            shift_q      <= '0;
            simplemul_q  <= 1'b0;
            vectstride_q <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            unique case (state)
                ST_IDLE: if (start_i) begin
                    a_addr_q     <= a_addr_i;
                    b_addr_q     <= b_addr_i;
                    c_addr_q     <= c_addr_i;
                    d_addr_q     <= d_addr_i;
                    nb_iter_q    <= nb_iter_i;
                    len_iter_q   <= len_iter_i;
                    shift_q      <= shift_i;
                    simplemul_q  <= simplemul_i;
                    vectstride_q <= vectstride_i;
                    if (nb_iter_i == '0 || len_iter_i == '0 || shift_i == '0) begin
                        err_o <= 1'b1;
                    end else begin
                        state       <= ST_ACQ_REQ;
                        periph_req  <= 1'b1;
                        periph_add  <= BASE_ADDR + OFF_ACQUIRE;
                        periph_wen  <= 1'b1;
                        periph_be   <= 4'hF;
                        periph_data <= '0;
                    end
                end
                ST_ACQ_REQ: if (periph_gnt) begin
                    periph_req <= 1'b0;
                    state      <= ST_ACQ_RESP;
                end
                ST_ACQ_RESP: if (periph_r_valid) begin
                    if (periph_r_data[31]) begin
                        if (RETRY_WAIT == 0) begin
                            state      <= ST_ACQ_REQ;
                            periph_req <= 1'b1;
                        end else begin
                            state     <= ST_ACQ_WAIT;
                            retry_cnt <= RETRY_WAIT - 32'd1;
                        end
                    end else begin
                        job_id_o    <= periph_r_data[7:0];
                        wr_idx      <= JOB_A_ADDR;
                        state       <= ST_WR_REQ;
                        periph_req  <= 1'b1;
                        periph_add  <= job_reg_addr(BASE_ADDR, JOB_A_ADDR);
                        periph_wen  <= 1'b0;
                        periph_be   <= 4'hF;
                        periph_data <= job_word(JOB_A_ADDR);
                    end
                end
                // Address and enables still hold the ACQUIRE request.
                ST_ACQ_WAIT: if (retry_cnt == '0) begin
                    state      <= ST_ACQ_REQ;
                    periph_req <= 1'b1;
                end else begin
                    retry_cnt <= retry_cnt - 32'd1;
                end
                ST_WR_REQ: if (periph_gnt) begin
                    periph_req <= 1'b0;
                    state      <= ST_WR_RESP;
                end
                ST_WR_RESP: if (periph_r_valid) begin
                    periph_req <= 1'b1;
                    if (wr_idx == JOB_VECTSTRIDE) begin
                        state       <= ST_TRIG_REQ;
                        periph_add  <= BASE_ADDR + OFF_TRIGGER;
                        periph_data <= '0;
                    end else begin
                        wr_idx      <= wr_idx + 3'd1;
                        state       <= ST_WR_REQ;
                        periph_add  <= job_reg_addr(BASE_ADDR, wr_idx + 3'd1);
                        periph_data <= job_word(wr_idx + 3'd1);
                    end
                end
                ST_TRIG_REQ: if (periph_gnt) begin
                    periph_req <= 1'b0;
                    state      <= ST_TRIG_RESP;
                end
                ST_TRIG_RESP: if (periph_r_valid) state <= ST_WAIT_EVT;
                ST_WAIT_EVT: if (evt_i) begin
                    state  <= ST_DONE;
                    done_o <= 1'b1;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_cfg_master.sv
// Self-checking bench for mac_cfg_master: periph slave model with a scoreboard
// of expected bus transactions, table-driven jobs and a few corner sequences.
`timescale 1ns/1ps
module tb_mac_cfg_master;

    localparam logic [31:0] BASE   = 32'h0010_0000;
    localparam int          RW     = 8;
    localparam int          IDW    = 10;
    localparam logic [31:0] A_TRIG = BASE + 32'h00;
    localparam logic [31:0] A_ACQ  = BASE + 32'h04;
    localparam logic [31:0] A_JOB  = BASE + 32'h40;

    typedef struct {
        logic [31:0] add;
        logic        wen;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [31:0] a, b, c, d, nb, len;
        logic [15:0] shift;
        logic        smul;
        logic [31:0] vs;
        int          gdly;
        logic [31:0] acq;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, evt = 1'b0, smul = 1'b0;
    logic [31:0] a_addr = '0, b_addr = '0, c_addr = '0, d_addr = '0;
    logic [31:0] nb = '0, len = '0, vs = '0;
    logic [15:0] shift = '0;
    logic busy, done, err;
    logic [7:0] job_id;
    logic req, gnt, wen, r_valid;
    logic [31:0] add, data, r_data;
    logic [3:0] be;
    logic [IDW-1:0] id, r_id;

    int checks = 0, errors = 0;
    int cyc = 0;
    int gnt_dly = 0, wait_cnt = 0;
    bit rsp_due = 0, held = 0, cur_is_acq = 0, last_acq_busy = 0;
    logic [31:0] rsp_data, h_add, h_data;
    logic h_wen;
    logic [3:0] h_be;
    int rv_cyc = 0, acq_reads = 0, txn_cnt = 0, done_cnt = 0, err_cnt = 0, req_cycles = 0;
    txn_t exp_q[$];
    logic [31:0] acq_q[$];
    vec_t vecs[7];

    mac_cfg_master #(.BASE_ADDR(BASE), .RETRY_WAIT(RW), .ID_WIDTH(IDW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .a_addr_i(a_addr), .b_addr_i(b_addr), .c_addr_i(c_addr), .d_addr_i(d_addr),
        .nb_iter_i(nb), .len_iter_i(len), .shift_i(shift), .simplemul_i(smul),
        .vectstride_i(vs), .evt_i(evt),
        .busy_o(busy), .done_o(done), .err_o(err), .job_id_o(job_id),
        .periph_req(req), .periph_gnt(gnt), .periph_add(add), .periph_wen(wen),
        .periph_be(be), .periph_data(data), .periph_id(id),
        .periph_r_data(r_data), .periph_r_valid(r_valid), .periph_r_id(r_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic score();
        txn_t e;
        txn_cnt++;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn actual add=%h required none", add);
        end else begin
            e = exp_q.pop_front();
            chk("txn_add", add, e.add);
            chk("txn_wen", 32'(wen), 32'(e.wen));
            if (!e.wen) chk("txn_data", data, e.data);
        end
        chk("txn_be", 32'(be), 32'hF);
        chk("txn_id", 32'(id), 32'd0);
        if (add == A_ACQ) begin
            acq_reads++;
            cur_is_acq = 1;
            rsp_data = (acq_q.size() != 0) ? acq_q.pop_front() : 32'd3;
        end else begin
            cur_is_acq = 0;
            rsp_data = 32'd0;
        end
    endtask

    // Periph slave: grants after gnt_dly wait cycles, answers one cycle after grant.
    initial begin
        gnt = 0; r_valid = 0; r_data = '0; r_id = '0;
        forever begin
            @(negedge clk);
            gnt = 0;
            r_valid = 0;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (req) req_cycles++;
            if (rst) begin
                wait_cnt = 0; rsp_due = 0; held = 0; last_acq_busy = 0;
            end else if (rsp_due) begin
                r_valid = 1;
                r_data = rsp_data;
                rsp_due = 0;
                if (cur_is_acq) begin
                    last_acq_busy = rsp_data[31];
                    rv_cyc = cyc;
                end
            end else if (req) begin
                if (!held) begin
                    held = 1;
                    h_add = add; h_data = data; h_wen = wen; h_be = be;
                    if (add == A_ACQ && last_acq_busy) chk("retry_gap", 32'(cyc - rv_cyc - 1), 32'(RW));
                end else begin
                    chk("stable_add", add, h_add);
                    chk("stable_data", data, h_data);
                    chk("stable_ctl", {27'd0, h_wen, h_be}, {27'd0, wen, be});
                end
                if (wait_cnt < gnt_dly) begin
                    wait_cnt++;
                end else begin
                    gnt = 1;
                    wait_cnt = 0;
                    held = 0;
                    score();
                    rsp_due = 1;
                end
            end else begin
                held = 0;
                wait_cnt = 0;
            end
        end
    end

    task automatic push_job(input vec_t v, input int n_acq);
        logic [31:0] w[8];
        w[0] = v.a; w[1] = v.b; w[2] = v.c; w[3] = v.d;
        w[4] = v.nb - 32'd1;
        w[5] = v.len - 32'd1;
        w[6] = {v.shift - 16'd1, 15'd0, v.smul};
        w[7] = v.vs;
        for (int i = 0; i < n_acq; i++) exp_q.push_back('{A_ACQ, 1'b1, 32'd0});
        for (int k = 0; k < 8; k++) exp_q.push_back('{A_JOB + 32'(4 * k), 1'b0, w[k]});
        exp_q.push_back('{A_TRIG, 1'b0, 32'd0});
    endtask

    task automatic drive_start(input vec_t v);
        @(negedge clk);
        a_addr = v.a; b_addr = v.b; c_addr = v.c; d_addr = v.d;
        nb = v.nb; len = v.len; shift = v.shift; smul = v.smul; vs = v.vs;
        gnt_dly = v.gdly;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_bus_done(input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && !rsp_due && !req) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            chk("bus_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic finish_evt();
        int d0 = done_cnt;
        evt = 1;
        @(negedge clk);
        evt = 0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("done_low", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic run_job(input vec_t v, input int n_acq, input logic [7:0] exp_id);
        int e0 = err_cnt, r0 = req_cycles, d0 = done_cnt, t0 = txn_cnt;
        if (!v.exp_err) push_job(v, n_acq);
        drive_start(v);
        chk("err_pulse", 32'(err), 32'(v.exp_err));
        if (v.exp_err) begin
            repeat (10) @(negedge clk);
            chk("err_no_req", 32'(req_cycles - r0), 32'd0);
            chk("err_once", 32'(err_cnt - e0), 32'd1);
            chk("err_idle", 32'(busy), 32'd0);
        end else begin
            wait_bus_done(1000);
            chk("txn_total", 32'(txn_cnt - t0), 32'(n_acq + 9));
            chk("job_id", 32'(job_id), 32'(exp_id));
            chk("busy_wait_evt", 32'(busy), 32'd1);
            chk("no_early_done", 32'(done_cnt - d0), 32'd0);
            finish_evt();
        end
    endtask

    task automatic wait_write(input int k, input int budget);
        int n = 0;
        while (!(req && add == A_JOB + 32'(4 * k)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("write_timeout", add, A_JOB + 32'(4 * k));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t v;
        int a0, d0, e0;
        vecs[0] = '{32'h1000_0000, 32'h1000_1000, 32'h1000_2000, 32'h1000_3000,
                    32'd4, 32'd6, 16'd2, 1'b1, 32'd4, 0, 32'd3, 1'b0};
        vecs[1] = '{32'hA000_0004, 32'hB000_0008, 32'hC000_000C, 32'hD000_0010,
                    32'd16, 32'd32, 16'd5, 1'b0, 32'h20, 5, 32'h12, 1'b0};
        vecs[2] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'd0, 32'd5, 16'd3, 1'b0, 32'd1, 0, 32'd3, 1'b1};
        vecs[3] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'd5, 32'd0, 16'd3, 1'b0, 32'd1, 0, 32'd3, 1'b1};
        vecs[4] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'd5, 32'd5, 16'd0, 1'b1, 32'd1, 0, 32'd3, 1'b1};
        vecs[5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'd1, 32'd1, 16'd1, 1'b0, 32'h0, 2, 32'h7F, 1'b0};
        vecs[6] = '{32'hFFFF_FFFC, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5555_AAAA,
                    32'hFFFF_FFFF, 32'h8000_0000, 16'hFFFF, 1'b1, 32'hFFFF_FFFF, 1, 32'h0000_01A5, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_add", add, 32'd0);
        chk("rst_wen", 32'(wen), 32'd1);
        chk("rst_be", 32'(be), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_job_id", 32'(job_id), 32'd0);
        rst = 0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            if (!vecs[i].exp_err) acq_q.push_back(vecs[i].acq);
            run_job(vecs[i], 1, vecs[i].acq[7:0]);
        end

        // Context busy twice, then granted with id 0.
        v = vecs[0];
        a0 = acq_reads;
        acq_q.push_back(32'hFFFF_FFFF);
        acq_q.push_back(32'hFFFF_FFFF);
        acq_q.push_back(32'h0000_0000);
        run_job(v, 3, 8'h00);
        chk("acq_reads", 32'(acq_reads - a0), 32'd3);

        // Reset in the middle of the k=5 write, then a clean job.
        v = vecs[0];
        v.gdly = 3;
        d0 = done_cnt;
        push_job(v, 1);
        acq_q.push_back(32'd3);
        drive_start(v);
        wait_write(5, 500);
        rst = 1;
        @(negedge clk);
        chk("rst_mid_req", 32'(req), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 0;
        exp_q.delete();
        acq_q.delete();
        repeat (10) @(negedge clk);
        chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_mid_job_id", 32'(job_id), 32'd0);
        acq_q.push_back(32'h0000_0044);
        run_job(vecs[0], 1, 8'h44);

        // Early event and a start attempt while busy, both during the write phase.
        v = vecs[0];
        d0 = done_cnt;
        e0 = err_cnt;
        push_job(v, 1);
        acq_q.push_back(32'd9);
        drive_start(v);
        wait_write(2, 500);
        evt = 1;
        start = 1;
        nb = 32'd0;
        @(negedge clk);
        evt = 0;
        start = 0;
        nb = v.nb;
        wait_bus_done(1000);
        repeat (10) @(negedge clk);
        chk("early_evt_busy", 32'(busy), 32'd1);
        chk("early_evt_no_done", 32'(done_cnt - d0), 32'd0);
        chk("busy_start_no_err", 32'(err_cnt - e0), 32'd0);
        chk("early_evt_job_id", 32'(job_id), 32'd9);
        finish_evt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_cfg_master.md
MAC_CFG_MASTER -- requirements
Module: mac_cfg_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0010_0000; accelerator peripheral base address.
REQ-002 Parameter RETRY_WAIT, default 8; idle cycles between ACQUIRE retries.
REQ-003 Parameter ID_WIDTH, default 10; periph transaction id width.
REQ-004 clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 start_i  in  1  job request pulse; sampled only in IDLE.
REQ-007 a_addr_i, b_addr_i, c_addr_i, d_addr_i  in  32 each  stream base pointers.
REQ-008 nb_iter_i, len_iter_i  in  32 each  true counts (>=1).
REQ-009 shift_i  in  16  true shift (>=1); simplemul_i  in  1; vectstride_i  in  32.
REQ-010 evt_i  in  1  accelerator completion event (core 0, event 0).
REQ-011 busy_o  out  1; done_o  out  1 (1-cycle pulse); err_o  out  1 (1-cycle pulse); job_id_o  out  8.
REQ-012 periph master (hwpe_ctrl_intf_periph.master): req, gnt, add[31:0], wen (0=write), be[3:0], data[31:0], id, r_data[31:0], r_valid, r_id.

Function
REQ-013 FSM states: IDLE, ACQ_REQ, ACQ_RESP, ACQ_WAIT, WR_REQ, WR_RESP, TRIG_REQ, TRIG_RESP, WAIT_EVT, DONE.
REQ-014 IDLE + start_i: all job inputs captured into internal regs same edge; if nb_iter_i, len_iter_i or shift_i is 0 -> err_o pulse next cycle, stay IDLE, no transaction.
REQ-015 ACQ_REQ: req=1, wen=1, add=BASE_ADDR+0x04, be=4'hF; held stable until gnt; on gnt -> ACQ_RESP.
REQ-016 ACQ_RESP: on r_valid, r_data[31]=1 (no free context) -> ACQ_WAIT; else job_id_o<=r_data[7:0], -> WR_REQ with write index 0.
REQ-017 ACQ_WAIT: count RETRY_WAIT cycles, then ACQ_REQ.
REQ-018 WR_REQ: write index k (0..7) to BASE_ADDR+0x40+4k, wen=0, be=4'hF; data per k: 0 a_addr, 1 b_addr, 2 c_addr, 3 d_addr, 4 nb_iter-1, 5 len_iter-1, 6 {shift-1, 15'b0, simplemul}, 7 vectstride.
REQ-019 WR_RESP: wait r_valid; k<7 -> k+1, WR_REQ; k=7 -> TRIG_REQ.
REQ-020 TRIG_REQ: write 0 to BASE_ADDR+0x00; on gnt -> TRIG_RESP; on r_valid -> WAIT_EVT.
REQ-021 WAIT_EVT: on evt_i -> DONE; DONE asserts done_o one cycle, -> IDLE.
REQ-022 At most one outstanding transaction; next req never asserted in the cycle r_valid arrives; minimum 2 cycles per transaction.
REQ-023 gnt in same cycle as req raised completes the request phase; r_valid accepted any cycle >=1 after gnt; r_valid outside a *_RESP state ignored.
REQ-024 req, add, wen, be, data stable while req=1 and gnt=0.
REQ-025 id driven constant 0; r_id not checked.
REQ-026 busy_o=1 in every state except IDLE; start_i while busy ignored.
REQ-027 evt_i asserted before WAIT_EVT ignored (not latched).
REQ-028 Subtractions in REQ-018 done in 32/16-bit modular arithmetic; inputs >=1 guaranteed by REQ-014.

Reset
REQ-029 rst_i: state=IDLE, req=0, add=0, wen=1, be=0, data=0, busy_o=0, done_o=0, err_o=0, job_id_o=0, k=0, retry counter=0.
REQ-030 rst_i mid-transaction: req drops next edge; pending response discarded; no done_o.

Structure
REQ-031 mac_package holds register offsets (TRIGGER 0x00, ACQUIRE 0x04, JOB base 0x40), job register indices 0..7, and the FSM state enum.
REQ-032 Single module; no sub-module.

Verification
REQ-033 Nominal: gnt immediate, r_valid +1, ACQUIRE returns 3; nb_iter=4, shift=2, simplemul=1 -> writes idx4=3, idx6=32'h0001_0001, job_id_o=3, trigger, evt_i -> done_o one cycle later.
REQ-034 Backpressure: gnt delayed 5 cycles each -> add/data unchanged during wait, 10 transactions total.
REQ-035 Busy context: ACQUIRE returns 32'hFFFF_FFFF twice then 0 -> exactly 3 ACQUIRE reads, RETRY_WAIT=8 idle cycles between.
REQ-036 nb_iter_i=0 with start_i -> err_o pulse, req never asserted.
REQ-037 rst_i asserted during write k=5 -> req=0 next cycle, IDLE, no done_o; fresh start_i completes normally.
REQ-038 Early evt_i during write phase, none later -> remains WAIT_EVT, busy_o=1.
